// File: rtl/cov_dist_q16.sv
// Distance producer: r = floor(sqrt(dx^2 + dy^2)) in Q16, one root bit per cycle, tag travels alongside.
// Latency DATA_WIDTH+2 edges accept-to-valid; no overlap, in_ready low until the output handshake completes.
module cov_dist_q16 #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] dx_q16,
    input  logic [DATA_WIDTH-1:0] dy_q16,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] r_q16,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  busy
);
    localparam int W  = DATA_WIDTH;
    localparam int RW = W + 1;
    localparam int IW = $clog2(W);

    typedef enum logic [1:0] {S_IDLE, S_SQ, S_ROOT, S_DONE} state_t;

    state_t              state_q;
    logic [W-1:0]        ax_q, ay_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [2*W-1:0]      rad_q;
    logic [RW-1:0]       rem_q;
    logic [W-1:0]        root_q;
    logic [IW-1:0]       iter_q;
    logic                fin_q;
    logic                in_ready_q, out_valid_q, busy_q;
    logic [W-1:0]        r_q;
    logic [TAG_WIDTH-1:0] out_tag_q;

    logic [W-1:0]        dx_abs, dy_abs;
    logic [2*W-1:0]      sum_d;
    logic [RW+1:0]       rem_shift, trial;
    logic [RW-1:0]       rem_d;
    logic [W-1:0]        root_d;

    // Two's-complement negate of the most-negative value yields 2^(W-1), which is exact when read unsigned.
    always_comb begin
        dx_abs = dx_q16[W-1] ? (~dx_q16 + 1'b1) : dx_q16;
        dy_abs = dy_q16[W-1] ? (~dy_q16 + 1'b1) : dy_q16;
        sum_d  = {{W{1'b0}}, ax_q} * {{W{1'b0}}, ax_q}
               + {{W{1'b0}}, ay_q} * {{W{1'b0}}, ay_q};
    end

    // Restoring square-root step; the remainder never exceeds 2*root, so RW bits hold it between steps.
    always_comb begin
        rem_shift = {rem_q, rad_q[2*W-1 -: 2]};
        trial     = {1'b0, root_q, 2'b01};
        rem_d     = rem_q;
        root_d    = root_q;
        if (rem_shift >= trial) begin
            rem_d  = RW'(rem_shift - trial);
            root_d = W'({root_q, 1'b1});
        end else begin
            rem_d  = RW'(rem_shift);
            root_d = W'({root_q, 1'b0});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ax_q        <= '0;
            ay_q        <= '0;
            tag_q       <= '0;
            rad_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            iter_q      <= '0;
            fin_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            r_q         <= '0;
            out_tag_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        ax_q       <= dx_abs;
                        ay_q       <= dy_abs;
                        tag_q      <= in_tag;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_SQ;
                    end
                end
                S_SQ: begin
                    rad_q   <= sum_d;
                    rem_q   <= '0;
                    root_q  <= '0;
                    iter_q  <= IW'(W - 1);
                    fin_q   <= 1'b0;
                    state_q <= S_ROOT;
                end
                S_ROOT: begin
                    // The edge after the last root bit publishes the result.
                    if (fin_q) begin
                        r_q         <= root_q;
                        out_tag_q   <= tag_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        rem_q  <= rem_d;
                        root_q <= root_d;
                        rad_q  <= rad_q << 2;
                        if (iter_q == '0) begin
                            fin_q <= 1'b1;
                        end else begin
                            iter_q <= iter_q - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign r_q16     = r_q;
    assign out_tag   = out_tag_q;
endmodule
